// File: rtl/window_gen.sv
// rtl/window_gen.sv - runtime-sized KxK sliding-window generator over a raster pixel stream
module window_gen #(
  parameter int DW    = 16,
  parameter int K     = 5,
  parameter int MAX_W = 28,
  parameter int MAX_H = 28,
  parameter int CW    = $clog2(MAX_W + 1),
  parameter int HW    = $clog2(MAX_H + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     img_w,
  input  logic [HW-1:0]     img_h,
  input  logic              in_valid,
  input  logic [DW-1:0]     din,
  output logic [K*K*DW-1:0] win,
  output logic              win_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  localparam int DEPTH = (K - 1) * MAX_W + K;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [CW-1:0] K_CW    = CW'(K);
  localparam logic [CW-1:0] KM1_CW  = CW'(K - 1);
  localparam logic [CW-1:0] MAXW_CW = CW'(MAX_W);
  localparam logic [HW-1:0] K_HW    = HW'(K);
  localparam logic [HW-1:0] KM1_HW  = HW'(K - 1);
  localparam logic [HW-1:0] MAXH_HW = HW'(MAX_H);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] img_w_q, col;
  logic [HW-1:0] img_h_q, row;
  logic          cfg_ok, accept, col_last, row_last;

  assign cfg_ok   = (img_w >= K_CW) && (img_w <= MAXW_CW) &&
                    (img_h >= K_HW) && (img_h <= MAXH_HW);
  assign accept   = (state == RUN) && in_valid && !start;
  assign col_last = (col == img_w_q - CW'(1));
  assign row_last = (row == img_h_q - HW'(1));
  assign busy     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = cfg_ok ? RUN : IDLE;
    else if (accept && col_last && row_last)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      img_w_q    <= K_CW;
      img_h_q    <= K_HW;
      cfg_err    <= 1'b0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= accept && (row >= KM1_HW) && (col >= KM1_CW);
      frame_done <= accept && col_last && row_last;
      if (start) begin
        if (cfg_ok) begin
          img_w_q <= img_w;
          img_h_q <= img_h;
          col     <= '0;
          row     <= '0;
          cfg_err <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + HW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Storage carries no reset; it only matters once a full window has been shifted in.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // Row stride through the chain follows the latched width, not MAX_W.
  always_comb begin
    win = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win[(r*K+c)*DW +: DW] = mem[AW'((K-1-r) * int'(img_w_q) + (K-1-c))];
  end

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - scoreboard bench for window_gen against an image-array reference model
module tb_window_gen;
  localparam int DW    = 16;
  localparam int K     = 5;
  localparam int MAX_W = 28;
  localparam int MAX_H = 28;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam int HW    = $clog2(MAX_H + 1);
  localparam int WB    = K * K * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] img_w = '0;
  logic [HW-1:0] img_h = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic [WB-1:0] win;
  logic          win_valid, busy, frame_done, cfg_err;

  window_gen #(.DW(DW), .K(K), .MAX_W(MAX_W), .MAX_H(MAX_H), .CW(CW), .HW(HW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
    .in_valid(in_valid), .din(din), .win(win), .win_valid(win_valid),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WB-1:0] w;
    int            due;
    bit            last;
    int            fid;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            frame_id = 0;
  int            win_cnt = 0;
  int            fd_cnt = 0;
  logic [WB-1:0] first_win, last_win;

  // reference model: the frame as a 2D image plus raster position
  logic [DW-1:0] img [MAX_W*MAX_H];
  bit            m_run = 0;
  bit            m_cfg = 0;
  int            m_w, m_h, m_row, m_col;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] el(logic [WB-1:0] w, int r, int c);
    return w[(r*K+c)*DW +: DW];
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_window: due cycle %0d, now %0d", q[0].due, cyc);
      void'(q.pop_front());
    end
    if (win_valid === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_win_valid: cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        if (e.due != cyc || e.w !== win || e.last !== frame_done) begin
          miscompares++;
          $display("FAIL window: cycle %0d (due %0d) frame_done %b (exp %b) got %h expected %h",
                   cyc, e.due, frame_done, e.last, win, e.w);
        end
        if (e.fid == frame_id) begin
          if (win_cnt == 0) first_win = win;
          last_win = win;
          win_cnt++;
        end
      end
    end else if (frame_done === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_without_window: cycle %0d", cyc);
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept(logic [DW-1:0] px);
    exp_t x;
    img[m_row*m_w + m_col] = px;
    x.last = (m_row == m_h - 1) && (m_col == m_w - 1);
    if (m_row >= K - 1 && m_col >= K - 1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          x.w[(r*K+c)*DW +: DW] = img[(m_row-K+1+r)*m_w + (m_col-K+1+c)];
      x.due = cyc + 1;
      x.fid = frame_id;
      q.push_back(x);
    end
    if (x.last) m_run = 0;
    if (m_col == m_w - 1) begin
      m_col = 0;
      m_row++;
    end else begin
      m_col++;
    end
  endtask

  task automatic do_start(int w, int h);
    frame_id++;
    win_cnt = 0;
    fd_cnt  = 0;
    start    = 1'b1;
    img_w    = CW'(w);
    img_h    = HW'(h);
    in_valid = 1'b1;
    din      = DW'($urandom);
    if (w >= K && w <= MAX_W && h >= K && h <= MAX_H) begin
      m_run = 1; m_cfg = 0; m_w = w; m_h = h; m_row = 0; m_col = 0;
    end else begin
      m_run = 0; m_cfg = 1;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    chk("cfg_err_after_start", {31'b0, cfg_err}, {31'b0, m_cfg});
    chk("busy_after_start", {31'b0, busy}, {31'b0, m_run});
  endtask

  // vmode: 0 continuous, 1 alternating, 2 random; rnd_data selects random pixels over raster index
  task automatic drive_pixels(int n, int vmode, bit rnd_data);
    int acc = 0;
    int ph  = 0;
    int guard = 0;
    while (m_run && (n < 0 || acc < n) && guard < 20000) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (ph % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      ph++;
      guard++;
      if (in_valid) begin
        din = rnd_data ? DW'($urandom) : DW'(m_row * m_w + m_col);
        model_accept(din);
        acc++;
      end else begin
        din = DW'($urandom);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(int n, bit iv);
    for (int i = 0; i < n; i++) begin
      in_valid = iv;
      din = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(int w, int h, bit idx);
    idle_cycles(3, 1'b0);
    chk("window_count", win_cnt, (h - K + 1) * (w - K + 1));
    chk("frame_done_count", fd_cnt, 1);
    chk("queue_drained", q.size(), 0);
    chk("busy_after_frame", {31'b0, busy}, 0);
    if (idx) begin
      chk("first_win_00", el(first_win, 0, 0), 0);
      chk("first_win_0k", el(first_win, 0, K - 1), K - 1);
      chk("first_win_k0", el(first_win, K - 1, 0), (K - 1) * w);
      chk("first_win_kk", el(first_win, K - 1, K - 1), (K - 1) * w + K - 1);
      chk("last_win_kk", el(last_win, K - 1, K - 1), w * h - 1);
    end
  endtask

  initial begin
    int w, h;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_win_valid", {31'b0, win_valid}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_frame_done", {31'b0, frame_done}, 0);
    chk("reset_cfg_err", {31'b0, cfg_err}, 0);
    rst_n = 1'b1;
    idle_cycles(3, 1'b1);
    chk("idle_ignores_in_valid", {31'b0, busy}, 0);

    do_start(28, 28); drive_pixels(-1, 0, 0); finish_frame(28, 28, 1);
    do_start(12, 12); drive_pixels(-1, 0, 0); finish_frame(12, 12, 1);
    do_start(28, 28); drive_pixels(-1, 1, 0); finish_frame(28, 28, 1);

    do_start(4, 12);
    idle_cycles(8, 1'b1);
    chk("illegal_w4_busy", {31'b0, busy}, 0);
    do_start(29, 12);
    idle_cycles(8, 1'b1);
    chk("illegal_w29_cfg_err", {31'b0, cfg_err}, 1);
    do_start(12, 12); drive_pixels(-1, 2, 1); finish_frame(12, 12, 0);

    do_start(28, 28); drive_pixels(301, 0, 0);
    do_start(28, 28); drive_pixels(-1, 0, 0); finish_frame(28, 28, 1);

    do_start(28, 28); drive_pixels(150, 0, 1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    tick();
    m_run = 0;
    m_cfg = 0;
    frame_id++;
    chk("midreset_win_valid", {31'b0, win_valid}, 0);
    chk("midreset_busy", {31'b0, busy}, 0);
    chk("midreset_frame_done", {31'b0, frame_done}, 0);
    chk("midreset_cfg_err", {31'b0, cfg_err}, 0);
    rst_n = 1'b1;
    idle_cycles(10, 1'b1);
    chk("post_reset_busy", {31'b0, busy}, 0);

    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(K, MAX_W);
      h = $urandom_range(K, MAX_H);
      do_start(w, h); drive_pixels(-1, 2, 1); finish_frame(w, h, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Parametrised sliding-window generator for the convolution datapath.
- Accepts a raster-order pixel stream and presents a full KxK window each cycle it is valid.
- Image width and height are runtime-configurable up to MAX_W/MAX_H, with window-valid and end-of-frame signalling.
- Successor to the fixed two-mode (28/12-wide, single-column) tap shifter; feeds the KxK MAC array.

Parameters:
- DW, 16, signed pixel width
- K, 5, kernel edge; window is KxK
- MAX_W, 28, maximum image width, sizes the storage
- MAX_H, 28, maximum image height
- CW, $clog2(MAX_W+1), width of img_w and col counter
- HW, $clog2(MAX_H+1), width of img_h and row counter

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  frame-start pulse; latches img_w/img_h, clears counters
- img_w  in  CW  image width, sampled on start
- img_h  in  HW  image height, sampled on start
- in_valid  in  1  din valid this cycle
- din  in  DW  signed pixel
- win  out  K*K*DW  window; element (r,c) at bits [(r*K+c)*DW +: DW]; r=0 top/oldest row, c=0 left/oldest column
- win_valid  out  1  win holds a fully in-image window
- busy  out  1  FSM in RUN
- frame_done  out  1  one-cycle pulse after the last pixel of a frame
- cfg_err  out  1  sticky; set on a start with illegal config

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; win_valid, busy, frame_done, cfg_err, col, row all 0.
  - Storage is not reset; its contents are don't-care.
  - win is don't-care while win_valid=0.
- Storage: shift chain of (K-1)*MAX_W+K entries of DW bits. mem[0] is the newest pixel.
  - Shifts only when in_valid=1 and state=RUN.
  - Holds otherwise, including in IDLE.
- Tap mapping: win(r,c) = mem[(K-1-r)*img_w_q + (K-1-c)].
  - The mapping is a runtime mux on the latched width img_w_q, combinational from storage.
- FSM states: IDLE, RUN.
  - start=1 in any state, legal config (K<=img_w<=MAX_W, K<=img_h<=MAX_H): latch img_w_q/img_h_q, col=0, row=0, cfg_err=0, go to RUN.
  - start=1 with illegal config: cfg_err=1, go to IDLE.
  - start has priority: din in the start cycle is dropped. start mid-frame aborts the frame with no frame_done.
  - RUN, in_valid=1: shift din in and advance col.
    - col wraps img_w_q-1 -> 0 with row+1.
    - Accepting pixel (img_h_q-1, img_w_q-1) -> IDLE, frame_done=1 the next cycle.
  - IDLE ignores in_valid.
- win_valid: registered.
  - Set for exactly one cycle after accepting a pixel at (row,col) with row>=K-1 and col>=K-1.
  - It is then aligned with the updated storage, so latency is 1 cycle from acceptance to window.
  - Windows straddling a row wrap are never flagged.
- Pixel bubbles (in_valid=0) insert gaps; win_valid=0 in bubble cycles and the window content is preserved.
- The last window's win_valid and frame_done assert in the same cycle.
- busy = (state==RUN).
- Windows per frame = (img_h-K+1)*(img_w-K+1).

Test Plan:
- 28x28, K=5, din=pixel index 0..783, in_valid continuous:
  - first win_valid the cycle after pixel 116 is accepted, with win(0,0)=0, win(0,4)=4, win(4,0)=112, win(4,4)=116;
  - 576 windows total; last window (4,4)=783;
  - frame_done coincident with the last win_valid.
- 12x12 after the 28x28 frame, no reset:
  - 64 windows; first window (0,0)=0, (4,4)=52; no stale 28-wide data flagged valid.
- 28x28 with in_valid toggling 1,0,1,0:
  - identical window sequence to the first scenario; win_valid never asserts in a bubble cycle.
- start with img_w=4, then img_w=29:
  - cfg_err=1, busy=0, din ignored.
  - A subsequent legal start clears cfg_err.
- start asserted after pixel 300 of a 28x28 frame, then a full new frame:
  - no frame_done for the aborted frame; new frame yields 576 correct windows.
- rst_n=0 for one cycle mid-frame:
  - all outputs 0 next cycle; in_valid ignored until the next start.
